// File: rtl/uart_rx_ctrl.sv
// UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a one-byte valid/ready holding register.
// Optional parity bit and check are compiled in with `define UART_RX_PARITY_EN.
module uart_rx_ctrl #(
    parameter int unsigned CLKS_PER_BIT = 5208,
    parameter int unsigned PARITY_ODD   = 0
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       en,
    input  logic       rx_in,
    input  logic       rx_ready,
    input  logic       err_clr,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam logic [15:0] LAST_CNT = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_CNT = 16'((CLKS_PER_BIT / 2) - 1);

    if ((CLKS_PER_BIT < 4) || (CLKS_PER_BIT > 65535) || (PARITY_ODD > 1)) begin : g_param_err
        $error("uart_rx_ctrl: CLKS_PER_BIT must be 4..65535 and PARITY_ODD 0 or 1");
    end

`ifdef UART_RX_PARITY_EN
    localparam logic ODD_BIT = 1'(PARITY_ODD);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd4,
        ST_BREAK = 3'd5
    } state_t;
`endif

    // XOR reduction of the data byte; 1 when it holds an odd number of ones.
    function automatic logic byte_parity(input logic [7:0] b);
        return ^b;
    endfunction

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_q, bit_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        valid_q, valid_d;
    logic        ferr_q, ferr_d;
    logic        ovr_q, ovr_d;
    logic        busy_q, busy_d;
    logic        meta_q, sync_q;
    logic        rx_s;
    logic        done_s;
    logic        stop_bad_s;
    logic        tick_s;
`ifdef UART_RX_PARITY_EN
    logic        fpar_q, fpar_d;
    logic        perr_q, perr_d;
`endif

    assign rx_s   = sync_q;
    assign tick_s = (cnt_q == LAST_CNT);

    // Two-flop synchronizer; resets to the idle-high line level so reset never looks like a start bit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= rx_in;
            sync_q <= meta_q;
        end
    end

    // Framing FSM, bit timing and holding-register next-state logic.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + 16'd1;
        bit_d      = bit_q;
        shift_d    = shift_q;
        data_d     = data_q;
        valid_d    = valid_q;
        ferr_d     = ferr_q;
        ovr_d      = ovr_q;
        done_s     = 1'b0;
        stop_bad_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        fpar_d     = fpar_q;
        perr_d     = perr_q;
`endif

        if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    cnt_d = 16'd0;
                    if (!rx_s) begin
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_CNT) begin
                        cnt_d = 16'd0;
                        bit_d = 3'd0;
                        if (!rx_s) begin
                            state_d = ST_DATA;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        state_d = ST_START;
                    end
                end
                ST_DATA: begin
                    if (tick_s) begin
                        cnt_d          = 16'd0;
                        shift_d[bit_q] = rx_s;
                        if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        state_d = ST_DATA;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick_s) begin
                        cnt_d   = 16'd0;
                        fpar_d  = byte_parity(shift_q) ^ rx_s ^ ODD_BIT;
                        state_d = ST_STOP;
                    end else begin
                        state_d = ST_PARITY;
                    end
                end
`endif
                ST_STOP: begin
                    if (tick_s) begin
                        cnt_d      = 16'd0;
                        done_s     = 1'b1;
                        stop_bad_s = !rx_s;
                        if (rx_s) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_BREAK;
                        end
                    end else begin
                        state_d = ST_STOP;
                    end
                end
                ST_BREAK: begin
                    cnt_d = 16'd0;
                    if (rx_s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_BREAK;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 16'd0;
                end
            endcase
        end

        // A completed frame loads only into an empty or simultaneously drained buffer.
        if (done_s && (!valid_q || rx_ready)) begin
            data_d  = shift_d;
            ferr_d  = stop_bad_s;
            valid_d = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_d  = fpar_q;
`endif
        end else if (valid_q && rx_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        if (done_s && valid_q && !rx_ready) begin
            ovr_d = 1'b1;
        end else if (err_clr) begin
            ovr_d = 1'b0;
        end else begin
            ovr_d = ovr_q;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 16'd0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
            fpar_q  <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            busy_q  <= busy_d;
`ifdef UART_RX_PARITY_EN
            fpar_q  <= fpar_d;
            perr_q  <= perr_d;
`endif
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign frame_err = ferr_q;
    assign overrun   = ovr_q;
    assign busy      = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err = perr_q;
`else
    assign parity_err = 1'b0;
`endif

endmodule
